// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand stage: registered ALU operands with EX/MEM and MEM/WB forwarding
// Forwarding and stall-time hold refresh exist only when ID_EX_FWD_EN is defined.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_wr_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_wr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              reg_write_o
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_rd_addr;
  logic [CTRL_W-1:0] r_alu_ctrl;
  logic              r_alu_src;
  logic              r_reg_write;

  logic              w_full;
  logic              w_in_ready;
  logic              w_load;
  logic              w_refresh;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  assign w_full     = (r_state == S_FULL);
  assign w_in_ready = rst_i & (!w_full | out_ready_i);
  assign w_load     = in_valid_i & w_in_ready & !flush_i;
  assign w_refresh  = w_full & !out_ready_i & !flush_i;

`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is hardwired.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [REG_AW-1:0] addr,
                                                input logic [DATA_W-1:0] held);
    logic [DATA_W-1:0] v;
    v = held;
    if (addr != '0) begin
      if (exmem_wr_i && (exmem_rd_i == addr))
        v = exmem_data_i;
      else if (memwb_wr_i && (memwb_rd_i == addr))
        v = memwb_data_i;
    end
    return v;
  endfunction

  assign w_fwd_rs = fwd_sel(r_rs_addr, r_rs_data);
  assign w_fwd_rt = fwd_sel(r_rt_addr, r_rt_data);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{exmem_rd_i, exmem_wr_i, exmem_data_i,
                          memwb_rd_i, memwb_wr_i, memwb_data_i,
                          r_rs_addr, r_rt_addr};
  assign w_fwd_rs = r_rs_data;
  assign w_fwd_rt = r_rt_data;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i)
      w_state_nxt = S_EMPTY;
    else if (w_load)
      w_state_nxt = S_FULL;
    else if (w_full && out_ready_i)
      w_state_nxt = S_EMPTY;
  end

  // While stalled, latch the forwarded operands so a producer retiring mid-stall is not lost.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_alu_ctrl  <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_load) begin
      r_rs_data   <= rs_data_i;
      r_rt_data   <= rt_data_i;
      r_imm       <= imm_i;
      r_rs_addr   <= rs_addr_i;
      r_rt_addr   <= rt_addr_i;
      r_rd_addr   <= rd_addr_i;
      r_alu_ctrl  <= alu_ctrl_i;
      r_alu_src   <= alu_src_i;
      r_reg_write <= reg_write_i;
    end else if (w_refresh) begin
      r_rs_data   <= w_fwd_rs;
      r_rt_data   <= w_fwd_rt;
    end
  end

  assign in_ready_o   = w_in_ready;
  assign out_valid_o  = w_full;
  assign src1_o       = w_full ? w_fwd_rs : '0;
  assign src2_o       = w_full ? (r_alu_src ? r_imm : w_fwd_rt) : '0;
  assign store_data_o = w_full ? w_fwd_rt : '0;
  assign ctrl_o       = w_full ? r_alu_ctrl : '0;
  assign rd_o         = w_full ? r_rd_addr : '0;
  assign reg_write_o  = w_full & r_reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o, flush_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [3:0]  alu_ctrl_i;
  logic        alu_src_i, reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_wr_i, memwb_wr_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;

  typedef struct packed {
    logic        v;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] st;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .flush_i(flush_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
    .exmem_rd_i(exmem_rd_i), .exmem_wr_i(exmem_wr_i), .exmem_data_i(exmem_data_i),
    .memwb_rd_i(memwb_rd_i), .memwb_wr_i(memwb_wr_i), .memwb_data_i(memwb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .src1_o(src1_o),
    .src2_o(src2_o), .ctrl_o(ctrl_o), .store_data_o(store_data_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o)
  );

  function automatic exp_t mk(input logic v, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] st, input logic [3:0] c,
                              input logic [4:0] rd, input logic rw);
    mk = '{v: v, s1: s1, s2: s2, st: st, c: c, rd: rd, rw: rw};
  endfunction

  function automatic exp_t obs();
    obs = '{v: out_valid_o, s1: src1_o, s2: src2_o, st: store_data_o,
            c: ctrl_o, rd: rd_o, rw: reg_write_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_in(input logic [4:0] rs_a, input logic [31:0] rs_d,
                         input logic [4:0] rt_a, input logic [31:0] rt_d,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic [3:0] ctrl, input logic src, input logic rw);
    in_valid_i = 1'b1; rs_addr_i = rs_a; rs_data_i = rs_d; rt_addr_i = rt_a;
    rt_data_i = rt_d; imm_i = imm; rd_addr_i = rd; alu_ctrl_i = ctrl;
    alu_src_i = src; reg_write_i = rw;
  endtask

  task automatic clear_fwd();
    exmem_rd_i = '0; exmem_wr_i = 1'b0; exmem_data_i = '0;
    memwb_rd_i = '0; memwb_wr_i = 1'b0; memwb_data_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; clear_fwd();
    load_in(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, 4'b0010, 1'b0, 1'b1);
    sb.push_back('0);
    tick(); tick();
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
    n_vec++;
    if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready_o); end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready_o); end
    in_valid_i = 1'b1;
    sb.push_back(mk(1'b1, 32'd5, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b1));
    tick();
    in_valid_i = 1'b0;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL first_load: got %h want %h", obs(), e); end
    tick();
    sb.push_back('0);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL drain_empty: got %h want %h", obs(), e); end
  endtask

  task automatic test_forward();
    load_in(5'd3, 32'h33, 5'd4, 32'h44, 32'h0, 5'd6, 4'b0000, 1'b0, 1'b1);
    tick();
    in_valid_i = 1'b0;
    exmem_rd_i = 5'd3; exmem_wr_i = 1'b1; exmem_data_i = 32'h11;
    memwb_rd_i = 5'd3; memwb_wr_i = 1'b1; memwb_data_i = 32'h22;
    sb.push_back(mk(1'b1, FWD ? 32'h11 : 32'h33, 32'h44, 32'h44, 4'b0000, 5'd6, 1'b1));
    #1;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL fwd_exmem_prio: got %h want %h", obs(), e); end
    exmem_wr_i = 1'b0;
    sb.push_back(mk(1'b1, FWD ? 32'h22 : 32'h33, 32'h44, 32'h44, 4'b0000, 5'd6, 1'b1));
    #1;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL fwd_memwb: got %h want %h", obs(), e); end
    tick();
    load_in(5'd0, 32'h55, 5'd4, 32'h44, 32'h0, 5'd6, 4'b0001, 1'b0, 1'b0);
    exmem_rd_i = 5'd0; exmem_wr_i = 1'b1; memwb_rd_i = 5'd0;
    tick();
    in_valid_i = 1'b0;
    sb.push_back(mk(1'b1, 32'h55, 32'h44, 32'h44, 4'b0001, 5'd6, 1'b0));
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL fwd_r0_never: got %h want %h", obs(), e); end
    clear_fwd();
    tick();
  endtask

  task automatic test_imm_select();
    load_in(5'd0, 32'hA, 5'd6, 32'd1, 32'hFFFF_FFFC, 5'd2, 4'b0110, 1'b1, 1'b1);
    memwb_rd_i = 5'd6; memwb_wr_i = 1'b1; memwb_data_i = 32'd9;
    sb.push_back(mk(1'b1, 32'hA, 32'hFFFF_FFFC, FWD ? 32'd9 : 32'd1, 4'b0110, 5'd2, 1'b1));
    tick();
    in_valid_i = 1'b0;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL imm_select: got %h want %h", obs(), e); end
    clear_fwd();
    tick();
  endtask

  task automatic test_stall_refresh();
    load_in(5'd2, 32'h20, 5'd4, 32'h10, 32'h999, 5'd8, 4'b0001, 1'b0, 1'b1);
    out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    memwb_rd_i = 5'd4; memwb_wr_i = 1'b1; memwb_data_i = 32'hAB;
    sb.push_back(mk(1'b1, 32'h20, FWD ? 32'hAB : 32'h10, FWD ? 32'hAB : 32'h10, 4'b0001, 5'd8, 1'b1));
    #1;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL stall_fwd: got %h want %h", obs(), e); end
    tick();
    memwb_wr_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b1, 32'h20, FWD ? 32'hAB : 32'h10, FWD ? 32'hAB : 32'h10, 4'b0001, 5'd8, 1'b1));
      #1;
      e = sb.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL stall_refresh_hold%0d: got %h want %h", i, obs(), e); end
      tick();
    end
    out_ready_i = 1'b1;
    load_in(5'd5, 32'h77, 5'd0, 32'h66, 32'h0, 5'd9, 4'b0111, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_load_ready: got %b want 1", in_ready_o); end
    sb.push_back(mk(1'b1, 32'h77, 32'h66, 32'h66, 4'b0111, 5'd9, 1'b0));
    tick();
    in_valid_i = 1'b0;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL drain_and_load: got %h want %h", obs(), e); end
    clear_fwd();
    tick();
  endtask

  task automatic test_backpressure();
    load_in(5'd1, 32'hA1, 5'd2, 32'hB2, 32'h10, 5'd3, 4'b0110, 1'b1, 1'b1);
    tick();
    out_ready_i = 1'b0;
    load_in(5'd7, 32'hDEAD, 5'd8, 32'hBEEF, 32'h20, 5'd9, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready_o); end
      sb.push_back(mk(1'b1, 32'hA1, 32'h10, 32'hB2, 4'b0110, 5'd3, 1'b1));
      e = sb.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL bp_hold%0d: got %h want %h", i, obs(), e); end
      tick();
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    sb.push_back('0);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL bp_release_empty: got %h want %h", obs(), e); end
  endtask

  task automatic test_flush();
    load_in(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd7, 4'b0010, 1'b0, 1'b1);
    tick();
    load_in(5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 5'd8, 4'b0001, 1'b0, 1'b1);
    flush_i = 1'b1;
    #1;
    n_vec++;
    if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready_o); end
    sb.push_back('0);
    tick();
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL flush_full: got %h want %h", obs(), e); end
    sb.push_back('0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL flush_empty_drop: got %h want %h", obs(), e); end
  endtask

  task automatic test_reset_midhold();
    load_in(5'd1, 32'hC1, 5'd2, 32'hC2, 32'h0, 5'd4, 4'b0000, 1'b0, 1'b1);
    out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    sb.push_back('0);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL async_reset_midhold: got %h want %h", obs(), e); end
    rst_i = 1'b1;
    tick();
    sb.push_back('0);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL reset_discard: got %h want %h", obs(), e); end
    out_ready_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      load_in(5'(i + 1), 32'h100 + i, 5'(i + 10), 32'h200 + i, 32'h0, 5'(i + 20),
              4'(i), 1'b0, i[0]);
      sb.push_back(mk(1'b1, 32'h100 + i, 32'h200 + i, 32'h200 + i, 4'(i), 5'(i + 20), i[0]));
      tick();
      e = sb.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, obs(), e); end
    end
    in_valid_i = 1'b0;
    tick();
    sb.push_back('0);
    e = sb.pop_front(); n_vec++;
    if (obs() !== e) begin n_err++; $display("FAIL b2b_drain: got %h want %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_imm_select();
    test_stall_refresh();
    test_backpressure();
    test_flush();
    test_reset_midhold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage that feeds the EX-stage ALU.
- Registers decoded operands and the 4-bit ALU control from ID.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Presents final src1/src2/ctrl to the ALU, with a single-entry valid/ready handshake on both sides plus flush.

Parameters:
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control width (ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111)
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- in_valid_i  in  1  ID presents an instruction
- in_ready_o  out  1  stage can accept this cycle
- flush_i  in  1  squash held and incoming instruction (branch taken)
- rs_data_i  in  DATA_W  register file rs value
- rt_data_i  in  DATA_W  register file rt value
- imm_i  in  DATA_W  sign-extended immediate
- rs_addr_i  in  REG_AW  rs index
- rt_addr_i  in  REG_AW  rt index
- rd_addr_i  in  REG_AW  destination index
- alu_ctrl_i  in  CTRL_W  ALU operation
- alu_src_i  in  1  1 = src2 from immediate
- reg_write_i  in  1  instruction writes rd
- exmem_rd_i  in  REG_AW  EX/MEM destination
- exmem_wr_i  in  1  EX/MEM writes
- exmem_data_i  in  DATA_W  EX/MEM result
- memwb_rd_i  in  REG_AW  MEM/WB destination
- memwb_wr_i  in  1  MEM/WB writes
- memwb_data_i  in  DATA_W  MEM/WB write-back value
- out_valid_o  out  1  ALU inputs valid
- out_ready_i  in  1  EX/MEM accepts this cycle
- src1_o  out  DATA_W  ALU src1
- src2_o  out  DATA_W  ALU src2
- ctrl_o  out  CTRL_W  ALU control
- store_data_o  out  DATA_W  forwarded rt value, for stores
- rd_o  out  REG_AW  destination passed down
- reg_write_o  out  1  write enable passed down, gated by out_valid_o

Behaviour:
- Reset (rst_i low, asynchronous): the entry is cleared and every output reads 0. in_ready_o reads 1 once reset is released. Reset asserted mid-hold discards the entry.
- Two states:
  - EMPTY: out_valid_o=0.
  - FULL: out_valid_o=1.
- in_ready_o = !FULL | out_ready_i (combinational).
- Load when in_valid_i & in_ready_o: all inputs are captured at the edge. State becomes FULL. Latency is 1 cycle from accept to out_valid_o.
- Transitions:
  - FULL & out_ready_i & no load -> EMPTY.
  - Simultaneous drain and load -> stays FULL with the new entry.
- flush_i has priority over load. Next state is EMPTY, and the incoming instruction is dropped even if in_valid_i is high. in_ready_o is unaffected by flush_i.
- Forwarding (combinational on the held rs/rt):
  - Source operand = exmem_data_i if exmem_wr_i & exmem_rd_i==addr & addr!=0.
  - Else memwb_data_i if memwb_wr_i & memwb_rd_i==addr & addr!=0.
  - Else the held register-file data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded and always reads the held value.
- Hold refresh: while FULL & !out_ready_i & !flush_i, the forwarded rs/rt values are written back into the held data each cycle. This keeps a producer that retires during the stall from being lost.
- Output selection:
  - src1_o = fwd_rs.
  - src2_o = alu_src ? imm : fwd_rt.
  - store_data_o = fwd_rt.
  - ctrl_o = held alu_ctrl.
  - All outputs read 0 when EMPTY.
- Widths: no arithmetic in this block; comparisons are on full REG_AW.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding and hold refresh as specified above.
- Undefined: src1/src2/store_data come directly from the held register-file values. The exmem_*/memwb_* inputs are ignored. The hazard unit must stall instead.

Test Plan:
- Reset: hold rst_i low with in_valid_i=1 -> out_valid_o=0, src1_o=src2_o=0, in_ready_o=1 after release. Then accept rs_data=5, rt_data=7, ctrl=0010 -> next cycle src1_o=5, src2_o=7, ctrl_o=0010, out_valid_o=1.
- Forward priority: held rs=3, exmem_rd=3/wr=1/data=0x11, memwb_rd=3/wr=1/data=0x22 -> src1_o=0x11. Drop exmem_wr -> src1_o=0x22. Set rs=0 with both matching -> src1_o=held value.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, fwd rt=9 -> src2_o=0xFFFFFFFC, store_data_o=9.
- Stall refresh: FULL, out_ready_i=0, memwb_rd=rt=4/data=0xAB for one cycle, then memwb_wr=0 -> src2_o stays 0xAB. Raise out_ready_i -> consumed, and a simultaneous new input loads in the same edge.
- Flush: FULL with in_valid_i=1 and flush_i=1 -> next cycle out_valid_o=0, reg_write_o=0, new instruction not presented.
- Back-pressure: out_ready_i=0 while FULL -> in_ready_o=0 and the entry is unchanged for 3 cycles except refresh.
